// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: reset, redirect load, or word increment (wraps at 16 bits).
module pc_counter
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              inc,
  output logic [WORD_W-1:0] pc
);

  // Reset wins, then redirect, then sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + WORD_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests words from memory, holds them for decode,
// follows redirects from execute and stops on the halt word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] pc_out,
  input  logic              br_take,
  input  logic [WORD_W-1:0] br_target,
  output logic              halted
);

  state_t            state;
  logic [WORD_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;

  // PC steering: redirect only in FETCH/HOLD, advance when decode takes the word.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (state == FETCH || state == HOLD) begin
      pc_load = br_take;
    end
    if (state == HOLD && !br_take) begin
      pc_inc = instr_ready;
    end
  end

  pc_counter #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (br_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign mem_addr = pc;

  // Fetch FSM with registered request/valid/halt outputs and instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr       <= '0;
      pc_out      <= RESET_PC;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH: begin
          if (br_take) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rdata == HALT_WORD) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state       <= HOLD;
              instr       <= mem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (br_take || instr_ready) begin
            state       <= FETCH;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
          end
        end
        HALT: begin
          state       <= HALT;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
